// File: rtl/countdown_pkg.sv
// Shared types and defaults for the countdown timer slice.
// Pure declarations: no latency, no flow control.
package countdown_pkg;
  localparam int CD_WIDTH    = 16;
  localparam int CD_PRESCALE = 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    EXPIRED
  } cd_state_t;
endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle between a timer owner (master) and the countdown timer (slave).
// Plain wires: no latency, no backpressure.
interface countdown_timer_if #(parameter int WIDTH = countdown_pkg::CD_WIDTH);
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             pause;
  logic [WIDTH-1:0] Q;
  logic             busy;
  logic             done;

  modport master (output load, load_value, start, pause, input Q, busy, done);
  modport slave  (input load, load_value, start, pause, output Q, busy, done);
endinterface

// File: rtl/tick_prescaler.sv
// Divides enabled cycles into ticks: tick is combinational, high on the last of every PRESCALE enabled cycles.
// No backpressure; hold freezes the count, clear restarts it from zero.
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic hold,
  output logic tick
);
  localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  assign tick = !hold && (cnt == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with start/pause and a one-cycle done; outputs registered, load visible one edge later.
// No backpressure. COUNTDOWN_AUTORELOAD_EN makes expiry reload the last loaded value and keep running.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH    = CD_WIDTH,
  parameter int PRESCALE = CD_PRESCALE
) (
  input logic               clock,
  input logic               reset,
  countdown_timer_if.slave  bus
);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  cd_state_t        state, state_nxt;
  logic [WIDTH-1:0] q_r, q_nxt;
  logic             done_r, done_nxt;
  logic             busy_r, busy_nxt;
  logic             pause_req, run_en, hold, tick, terminal;
  logic [WIDTH-1:0] expire_value;

  // start outranks pause, so both together in RUN keeps counting
  assign pause_req = bus.pause && !bus.start;
  assign run_en    = (state == RUN) && !bus.load && !pause_req;
  assign hold      = !run_en;
  assign terminal  = tick && (q_r == ONE);

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clock (clock),
    .reset (reset),
    .clear (bus.load),
    .hold  (hold),
    .tick  (tick)
  );

`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_r;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      reload_r <= '0;
    end else if (bus.load) begin
      reload_r <= bus.load_value;
    end
  end

  assign expire_value = reload_r;
`else
  assign expire_value = '0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      q_r    <= '0;
      done_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      q_r    <= q_nxt;
      done_r <= done_nxt;
      busy_r <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.load) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start) state_nxt = (q_r != '0) ? RUN : EXPIRED;
        RUN: begin
          if (pause_req)     state_nxt = PAUSED;
          else if (terminal) state_nxt = (expire_value != '0) ? RUN : EXPIRED;
        end
        PAUSED:  if (bus.start) state_nxt = RUN;
        EXPIRED: state_nxt = EXPIRED;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    q_nxt    = q_r;
    done_nxt = 1'b0;
    if (bus.load) begin
      q_nxt = bus.load_value;
    end else begin
      case (state)
        IDLE: if (bus.start && q_r == '0) done_nxt = 1'b1;
        RUN: begin
          if (terminal) begin
            q_nxt    = expire_value;
            done_nxt = 1'b1;
          end else if (tick && q_r != '0) begin
            q_nxt = q_r - ONE;
          end
        end
        default: q_nxt = q_r;
      endcase
    end
    busy_nxt = (state_nxt == RUN) || (state_nxt == PAUSED);
  end

  assign bus.Q    = q_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench: one PRESCALE=1 and one PRESCALE=4 timer share the same stimulus.
module tb_countdown_timer;
  logic        clock = 1'b0;
  logic        reset;
  logic        load, start, pause;
  logic [15:0] load_value;
  int          errors = 0;
  int          checks = 0;

  always #5 clock = ~clock;

  countdown_timer_if #(.WIDTH(16)) i1 ();
  countdown_timer_if #(.WIDTH(16)) i4 ();

  assign i1.load = load;  assign i1.load_value = load_value;
  assign i1.start = start; assign i1.pause = pause;
  assign i4.load = load;  assign i4.load_value = load_value;
  assign i4.start = start; assign i4.pause = pause;

  countdown_timer #(.WIDTH(16), .PRESCALE(1)) dut1 (.clock(clock), .reset(reset), .bus(i1));
  countdown_timer #(.WIDTH(16), .PRESCALE(4)) dut4 (.clock(clock), .reset(reset), .bus(i4));

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; load_value = v;
    cyc();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; load_value = '0;
    #3;
    checks++; if (i1.Q !== 16'd0) begin errors++; $display("FAIL reset_q1: got %0d expected 0", i1.Q); end
    checks++; if (i1.busy !== 1'b0 || i1.done !== 1'b0) begin errors++; $display("FAIL reset_flags1: busy=%b done=%b expected 0 0", i1.busy, i1.done); end
    checks++; if (i4.Q !== 16'd0) begin errors++; $display("FAIL reset_q4: got %0d expected 0", i4.Q); end
    cyc();
    reset = 1'b1;
    cyc();
    checks++; if (i1.Q !== 16'd0 || i1.busy !== 1'b0 || i1.done !== 1'b0) begin errors++; $display("FAIL post_reset_idle: Q=%0d busy=%b done=%b expected 0 0 0", i1.Q, i1.busy, i1.done); end
  endtask

  task automatic test_load();
    do_load(16'd5);
    checks++; if (i1.Q !== 16'd5) begin errors++; $display("FAIL load_q: got %0d expected 5", i1.Q); end
    checks++; if (i1.busy !== 1'b0) begin errors++; $display("FAIL load_busy: got %b expected 0", i1.busy); end
  endtask

  task automatic test_oneshot();
    int ndone;
    do_load(16'd5);
    do_start();
    checks++; if (i1.busy !== 1'b1 || i1.Q !== 16'd5) begin errors++; $display("FAIL oneshot_start: busy=%b Q=%0d expected 1 5", i1.busy, i1.Q); end
    ndone = 0;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      if (i1.done === 1'b1) ndone++;
      checks++; if (i1.Q !== 16'(5 - k)) begin errors++; $display("FAIL oneshot_q[%0d]: got %0d expected %0d", k, i1.Q, 5 - k); end
      checks++; if (i1.done !== (k == 5)) begin errors++; $display("FAIL oneshot_done[%0d]: got %b expected %b", k, i1.done, (k == 5)); end
      checks++; if (i1.busy !== (k < 5)) begin errors++; $display("FAIL oneshot_busy[%0d]: got %b expected %b", k, i1.busy, (k < 5)); end
    end
    cyc();
    checks++; if (ndone != 1 || i1.done !== 1'b0 || i1.busy !== 1'b0) begin errors++; $display("FAIL oneshot_after: pulses=%0d done=%b busy=%b expected 1 0 0", ndone, i1.done, i1.busy); end
    start = 1'b1; pause = 1'b1;
    cyc();
    start = 1'b0; pause = 1'b0;
    cyc();
    checks++; if (i1.Q !== 16'd0 || i1.done !== 1'b0 || i1.busy !== 1'b0) begin errors++; $display("FAIL expired_ignores_start: Q=%0d done=%b busy=%b expected 0 0 0", i1.Q, i1.done, i1.busy); end
  endtask

  task automatic test_prescale();
    logic [15:0] exp_q;
    do_load(16'd2);
    do_start();
    for (int k = 1; k <= 8; k++) begin
      cyc();
      exp_q = (k < 4) ? 16'd2 : (k < 8) ? 16'd1 : 16'd0;
      checks++; if (i4.Q !== exp_q) begin errors++; $display("FAIL pre4_q[%0d]: got %0d expected %0d", k, i4.Q, exp_q); end
      checks++; if (i4.done !== (k == 8)) begin errors++; $display("FAIL pre4_done[%0d]: got %b expected %b", k, i4.done, (k == 8)); end
    end
  endtask

  task automatic test_pause();
    do_load(16'd10);
    do_start();
    cyc(); cyc(); cyc();
    checks++; if (i1.Q !== 16'd7) begin errors++; $display("FAIL pause_pre: got %0d expected 7", i1.Q); end
    pause = 1'b1;
    cyc();
    pause = 1'b0;
    checks++; if (i1.Q !== 16'd7 || i1.busy !== 1'b1) begin errors++; $display("FAIL pause_edge: Q=%0d busy=%b expected 7 1", i1.Q, i1.busy); end
    for (int k = 5; k <= 7; k++) begin
      if (k == 6) pause = 1'b1;
      cyc();
      pause = 1'b0;
      checks++; if (i1.Q !== 16'd7) begin errors++; $display("FAIL paused_hold[%0d]: got %0d expected 7", k, i1.Q); end
    end
    do_start();
    checks++; if (i1.Q !== 16'd7) begin errors++; $display("FAIL resume_edge: got %0d expected 7", i1.Q); end
    for (int k = 9; k <= 15; k++) begin
      cyc();
      checks++; if (i1.Q !== 16'(15 - k) || i1.done !== (k == 15)) begin errors++; $display("FAIL resume_run[%0d]: Q=%0d done=%b expected %0d %b", k, i1.Q, i1.done, 15 - k, (k == 15)); end
    end
  endtask

  task automatic test_zero();
    do_load(16'd0);
    checks++; if (i1.busy !== 1'b0) begin errors++; $display("FAIL zero_idle_busy: got %b expected 0", i1.busy); end
    do_start();
    checks++; if (i1.done !== 1'b1 || i1.busy !== 1'b0 || i1.Q !== 16'd0) begin errors++; $display("FAIL zero_expire: done=%b busy=%b Q=%0d expected 1 0 0", i1.done, i1.busy, i1.Q); end
    cyc();
    checks++; if (i1.done !== 1'b0 || i1.busy !== 1'b0) begin errors++; $display("FAIL zero_after: done=%b busy=%b expected 0 0", i1.done, i1.busy); end
  endtask

  task automatic test_reset_mid();
    do_load(16'd8);
    do_start();
    cyc(); cyc(); cyc(); cyc();
    checks++; if (i1.Q !== 16'd4 || i1.busy !== 1'b1) begin errors++; $display("FAIL rmid_pre: Q=%0d busy=%b expected 4 1", i1.Q, i1.busy); end
    #2 reset = 1'b0;
    #1;
    checks++; if (i1.Q !== 16'd0 || i1.busy !== 1'b0 || i1.done !== 1'b0) begin errors++; $display("FAIL rmid_async: Q=%0d busy=%b done=%b expected 0 0 0", i1.Q, i1.busy, i1.done); end
    cyc();
    reset = 1'b1;
    do_start();
    checks++; if (i1.done !== 1'b1 || i1.busy !== 1'b0 || i1.Q !== 16'd0) begin errors++; $display("FAIL rmid_restart: done=%b busy=%b Q=%0d expected 1 0 0", i1.done, i1.busy, i1.Q); end
  endtask

`ifdef COUNTDOWN_AUTORELOAD_EN
  task automatic test_autoreload();
    logic [15:0] exp_q;
    do_load(16'd3);
    do_start();
    for (int k = 1; k <= 7; k++) begin
      cyc();
      exp_q = (k % 3 == 1) ? 16'd2 : (k % 3 == 2) ? 16'd1 : 16'd3;
      checks++; if (i1.Q !== exp_q || i1.done !== (k % 3 == 0) || i1.busy !== 1'b1) begin errors++; $display("FAIL autoreload[%0d]: Q=%0d done=%b busy=%b expected %0d %b 1", k, i1.Q, i1.done, i1.busy, exp_q, (k % 3 == 0)); end
    end
    do_load(16'd0);
    checks++; if (i1.Q !== 16'd0 || i1.busy !== 1'b0 || i1.done !== 1'b0) begin errors++; $display("FAIL ar_load0: Q=%0d busy=%b done=%b expected 0 0 0", i1.Q, i1.busy, i1.done); end
    do_start();
    checks++; if (i1.done !== 1'b1 || i1.busy !== 1'b0) begin errors++; $display("FAIL ar_expire: done=%b busy=%b expected 1 0", i1.done, i1.busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
`ifdef COUNTDOWN_AUTORELOAD_EN
    test_autoreload();
`else
    test_oneshot();
    test_prescale();
    test_pause();
`endif
    test_zero();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter with start/pause control and a terminal-count pulse. It is the counting-down complement of the lab's enable-driven up-counter. Software or a test FSM loads a value, starts the count, and receives a one-cycle `done` when the count reaches zero. It sits beside the up-counter in the lab datapath and drives interval timing and timeouts.

## Interface
- `WIDTH`, 16: counter width in bits.
- `PRESCALE`, 1: clock cycles per decrement tick. Legal values are 1 or greater.

Reset is asynchronous and active-low on `reset`; the clock is `clock`.

- `clock`  in  1  system clock; all state changes on the positive edge.
- `reset`  in  1  asynchronous, active-low reset.
- `load`  in  1  loads `load_value` into the count and the reload register.
- `load_value`  in  WIDTH  value captured by `load`.
- `start`  in  1  begin or resume counting.
- `pause`  in  1  freeze counting while running.
- `Q`  out  WIDTH  current count value.
- `busy`  out  1  high in RUN and PAUSED.
- `done`  out  1  one-cycle pulse on terminal count.

## Operation
- States are IDLE, RUN, PAUSED and EXPIRED. Reset forces IDLE, `Q`=0, reload register=0, prescaler=0, `busy`=0 and `done`=0.
- Control priority in a single cycle is `load` > `start` > `pause`.
- `load` works from any state. It sets `Q`=`load_value` and the reload register=`load_value`, clears the prescaler, and moves to IDLE. Any pending tick is discarded.
- IDLE with `start`:
  - `Q`≠0 goes to RUN.
  - `Q`=0 goes to EXPIRED and pulses `done`.
- RUN:
  - The prescaler counts 0..PRESCALE-1. Each wrap is a tick, and each tick decrements `Q` by 1.
  - A tick with `Q`=1 sets `Q` to 0, pulses `done` and moves to EXPIRED.
  - `pause` moves to PAUSED. The prescaler holds and no decrement happens on that edge.
- PAUSED:
  - `start` returns to RUN and the prescaler resumes from its held value.
  - `pause` has no effect.
- EXPIRED:
  - `Q` holds 0 and `done` is low after the pulse.
  - `start` and `pause` are ignored; only `load` or `reset` leave this state.
- Arithmetic is unsigned modulo 2^WIDTH. `Q` never underflows because decrement is only applied when `Q`≥1.

## Timing
- All outputs are registered.
- `load` is visible on `Q` one edge after it is sampled.
- Start edge to `done`:
  - `done` rises on the edge N·PRESCALE cycles after the start edge, where N is the loaded value.
  - `Q` reads 0 in that same cycle.
  - Example: with PRESCALE=1 and N=3, `Q` steps 3→2→1→0 and `done` is high with `Q`=0.
- `done` is high for exactly one cycle per expiry.
- `busy` rises on the edge that enters RUN and falls on the edge that enters EXPIRED or IDLE.
- Asserting `reset` at any point zeroes all outputs immediately, without waiting for a clock edge.
- The first edge after reset deasserts behaves as IDLE.

## Configuration
- `COUNTDOWN_AUTORELOAD_EN` defined:
  - A terminal tick in RUN loads the reload register into `Q`, stays in RUN and pulses `done`. The result is a periodic `done` every N·PRESCALE cycles.
  - If the reload register is 0, the timer goes to EXPIRED as normal.
- `COUNTDOWN_AUTORELOAD_EN` undefined:
  - There is no reload register. The behaviour is one-shot, as described above.
  - `load` only sets `Q`.

## Structure
- Shared package `countdown_pkg`: a state enum `cd_state_t` with IDLE, RUN, PAUSED and EXPIRED, plus default WIDTH/PRESCALE constants.
- One sub-module, `tick_prescaler`, with parameter PRESCALE and ports `clock`, `reset`, `clear`, `hold` and `tick`.
  - With PRESCALE=1, `tick` is high every enabled cycle.
- The top level holds the FSM, the count register and, under the macro, the reload register.

## Test plan
- PRESCALE=1, load 5, start: `Q` = 4,3,2,1,0 on successive edges; `done` is high exactly once, in the cycle with `Q`=0; then `busy`=0.
- PRESCALE=4, load 2, start: `done` arrives 8 cycles after the start edge; `Q` is held constant between ticks.
- Load 10, start, pause after 3 decrements for 5 cycles, then start: `Q` holds 7 while paused; `done` arrives 15 cycles after the first start.
- Load 0, start: the timer goes to EXPIRED with a one-cycle `done`; `busy` is never high.
- Load 8, start, assert `reset` at `Q`=4: `Q`, `busy` and `done` go to 0 at once; a later start with no load goes to EXPIRED and pulses `done`.
- With `COUNTDOWN_AUTORELOAD_EN`, PRESCALE=1, load 3, start: `done` pulses every 3 cycles with `Q` cycling 2,1,3,2,1,3…; `load` 0 mid-run gives IDLE, and a following start gives EXPIRED.
